// File: rtl/jtframe_credits_pkg.sv
// ---------------------------------------------------------------------------
// jtframe_credits_pkg
// Shared definitions for the credits console: FSM state encoding, page
// geometry and the control codes the console interprets.
// Optional feature macro: JTFRAME_CREDITS_CONSOLE_HEX_EN (adds the hex-print
// states HEX_ARG / HEX_LO).
// ---------------------------------------------------------------------------
package jtframe_credits_pkg;

    localparam int         COLS       = 32;
    localparam int         ROWS       = 32;
    localparam logic [6:0] BLANK_CHAR = 7'h20;
    localparam logic [9:0] LAST_CELL  = 10'(COLS*ROWS-1);

    localparam logic [7:0] CC_COL0 = 8'h01;
    localparam logic [7:0] CC_COL1 = 8'h02;
    localparam logic [7:0] CC_LF   = 8'h0A;
    localparam logic [7:0] CC_FF   = 8'h0C;
    localparam logic [7:0] CC_CR   = 8'h0D;
    localparam logic [7:0] CC_HEX  = 8'h1B;

`ifdef JTFRAME_CREDITS_CONSOLE_HEX_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_WRITE, ST_CLEAR, ST_HEX_ARG, ST_HEX_LO
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE, ST_WRITE, ST_CLEAR
    } state_t;
`endif

endpackage

// File: rtl/jtframe_hex2ascii.sv
// ---------------------------------------------------------------------------
// jtframe_hex2ascii
// Combinational nibble to uppercase ASCII hex digit ('0'..'9', 'A'..'F').
//   i_nibble  in  4  value 0..15
//   o_ascii   out 7  ASCII code
// ---------------------------------------------------------------------------
module jtframe_hex2ascii (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_ascii
);

    always_comb begin
        if (i_nibble < 4'd10) o_ascii = 7'h30 + {3'b000, i_nibble};
        else                  o_ascii = 7'h37 + {3'b000, i_nibble};
    end

endmodule

// File: rtl/jtframe_credits_console.sv
// ---------------------------------------------------------------------------
// jtframe_credits_console
// Character-stream writer for the 32x32 credits overlay VRAM. Bytes arrive on
// a valid/ready handshake; printable codes are written at an auto-advancing
// cursor, control codes move the cursor, pick the colour or clear the page.
//   i_clk         in   1   system clock
//   i_rst         in   1   synchronous active-high reset
//   i_din         in   8   input byte
//   i_din_valid   in   1   i_din valid
//   o_din_ready   out  1   byte accepted when valid && ready
//   i_clr         in   1   single-cycle clear-screen request
//   o_vram_din    out  8   {colour, char[6:0]}
//   o_vram_addr   out  10  {row, col}
//   o_vram_we     out  1   write strobe
//   o_busy        out  1   clear in progress
//   o_cursor      out  10  current {row, col}
// Optional feature macro: JTFRAME_CREDITS_CONSOLE_HEX_EN -- 0x1B prints the
// next byte as two hex digits. Without it 0x1B is ignored.
// ---------------------------------------------------------------------------
module jtframe_credits_console
    import jtframe_credits_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_din,
    input  logic       i_din_valid,
    output logic       o_din_ready,
    input  logic       i_clr,
    output logic [7:0] o_vram_din,
    output logic [9:0] o_vram_addr,
    output logic       o_vram_we,
    output logic       o_busy,
    output logic [9:0] o_cursor
);

    state_t     r_state, w_state_nxt;
    logic [4:0] r_row, r_col;
    logic       r_colour;
    logic       r_we;
    logic [9:0] r_addr;
    logic [7:0] r_data;
    logic       r_busy;

    logic       w_rdy_state;
    logic       w_accept;
    logic       w_print;
    logic       w_start_clear;
    logic [9:0] w_cursor;
    logic [9:0] w_cursor_inc;

    logic       w_we_nxt, w_busy_nxt, w_colour_nxt;
    logic [9:0] w_addr_nxt, w_cursor_nxt;
    logic [7:0] w_data_nxt;

`ifdef JTFRAME_CREDITS_CONSOLE_HEX_EN
    logic       r_hex_pend, w_hex_pend_nxt;
    logic [3:0] r_hex_lo,   w_hex_lo_nxt;
    logic [6:0] w_hex_hi_asc, w_hex_lo_asc;

    jtframe_hex2ascii u_hex_hi (.i_nibble(i_din[7:4]), .o_ascii(w_hex_hi_asc));
    jtframe_hex2ascii u_hex_lo (.i_nibble(r_hex_lo),   .o_ascii(w_hex_lo_asc));

    assign w_rdy_state = (r_state == ST_IDLE) || (r_state == ST_HEX_ARG);
`else
    assign w_rdy_state = (r_state == ST_IDLE);
`endif

    assign o_din_ready = w_rdy_state && !i_clr && !i_rst;
    assign w_accept    = o_din_ready && i_din_valid;
    assign w_print     = (i_din >= 8'h20) && (i_din <= 8'h7E);
    assign w_cursor    = {r_row, r_col};
    // Column overflow carries into the row and the row wraps at 32, which is
    // exactly a 10-bit increment of {row, col}.
    assign w_cursor_inc = w_cursor + 10'd1;

    // A clear (re)starts whenever CLEAR is entered or clr arrives during it.
    assign w_start_clear = (w_state_nxt == ST_CLEAR) &&
                           ((r_state != ST_CLEAR) || i_clr);

    // ---- state register ----
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // ---- next state ----
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_clr)                w_state_nxt = ST_CLEAR;
                else if (w_accept) begin
                    if (w_print)             w_state_nxt = ST_WRITE;
                    else if (i_din == CC_FF) w_state_nxt = ST_CLEAR;
`ifdef JTFRAME_CREDITS_CONSOLE_HEX_EN
                    else if (i_din == CC_HEX) w_state_nxt = ST_HEX_ARG;
`endif
                end
            end
            ST_WRITE: begin
                if (i_clr)           w_state_nxt = ST_CLEAR;
`ifdef JTFRAME_CREDITS_CONSOLE_HEX_EN
                else if (r_hex_pend) w_state_nxt = ST_HEX_LO;
`endif
                else                 w_state_nxt = ST_IDLE;
            end
            ST_CLEAR: begin
                if (!i_clr && r_addr == LAST_CELL) w_state_nxt = ST_IDLE;
            end
`ifdef JTFRAME_CREDITS_CONSOLE_HEX_EN
            ST_HEX_ARG: begin
                if (i_clr)         w_state_nxt = ST_CLEAR;
                else if (w_accept) w_state_nxt = ST_WRITE;
            end
            ST_HEX_LO: begin
                if (i_clr) w_state_nxt = ST_CLEAR;
                else       w_state_nxt = ST_WRITE;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---- outputs: next values of the registered VRAM port and cursor ----
    always_comb begin
        w_we_nxt     = 1'b0;
        w_busy_nxt   = 1'b0;
        w_addr_nxt   = r_addr;
        w_data_nxt   = r_data;
        w_cursor_nxt = w_cursor;
        w_colour_nxt = r_colour;
`ifdef JTFRAME_CREDITS_CONSOLE_HEX_EN
        w_hex_pend_nxt = r_hex_pend;
        w_hex_lo_nxt   = r_hex_lo;
`endif
        if (w_start_clear) begin
            w_we_nxt     = 1'b1;
            w_busy_nxt   = 1'b1;
            w_addr_nxt   = 10'd0;
            w_data_nxt   = {r_colour, BLANK_CHAR};
            w_cursor_nxt = 10'd0;
`ifdef JTFRAME_CREDITS_CONSOLE_HEX_EN
            w_hex_pend_nxt = 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_print) begin
                            w_we_nxt   = 1'b1;
                            w_addr_nxt = w_cursor;
                            w_data_nxt = {r_colour, i_din[6:0]};
                        end else begin
                            case (i_din)
                                CC_LF:   w_cursor_nxt = {r_row + 5'd1, 5'd0};
                                CC_CR:   w_cursor_nxt = {r_row, 5'd0};
                                CC_COL0: w_colour_nxt = 1'b0;
                                CC_COL1: w_colour_nxt = 1'b1;
                                default: ;
                            endcase
                        end
                    end
                end
                ST_WRITE: w_cursor_nxt = w_cursor_inc;
                ST_CLEAR: begin
                    if (r_addr != LAST_CELL) begin
                        w_we_nxt   = 1'b1;
                        w_busy_nxt = 1'b1;
                        w_addr_nxt = r_addr + 10'd1;
                    end
                end
`ifdef JTFRAME_CREDITS_CONSOLE_HEX_EN
                ST_HEX_ARG: begin
                    if (w_accept) begin
                        w_we_nxt       = 1'b1;
                        w_addr_nxt     = w_cursor;
                        w_data_nxt     = {r_colour, w_hex_hi_asc};
                        w_hex_lo_nxt   = i_din[3:0];
                        w_hex_pend_nxt = 1'b1;
                    end
                end
                ST_HEX_LO: begin
                    // cursor already advanced past the high digit
                    w_we_nxt       = 1'b1;
                    w_addr_nxt     = w_cursor;
                    w_data_nxt     = {r_colour, w_hex_lo_asc};
                    w_hex_pend_nxt = 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

    // ---- datapath registers ----
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_we     <= 1'b0;
            r_busy   <= 1'b0;
            r_addr   <= 10'd0;
            r_data   <= 8'd0;
            r_row    <= 5'd0;
            r_col    <= 5'd0;
            r_colour <= 1'b1;
`ifdef JTFRAME_CREDITS_CONSOLE_HEX_EN
            r_hex_pend <= 1'b0;
            r_hex_lo   <= 4'd0;
`endif
        end else begin
            r_we     <= w_we_nxt;
            r_busy   <= w_busy_nxt;
            r_addr   <= w_addr_nxt;
            r_data   <= w_data_nxt;
            r_row    <= w_cursor_nxt[9:5];
            r_col    <= w_cursor_nxt[4:0];
            r_colour <= w_colour_nxt;
`ifdef JTFRAME_CREDITS_CONSOLE_HEX_EN
            r_hex_pend <= w_hex_pend_nxt;
            r_hex_lo   <= w_hex_lo_nxt;
`endif
        end
    end

    assign o_vram_we   = r_we;
    assign o_vram_addr = r_addr;
    assign o_vram_din  = r_data;
    assign o_busy      = r_busy;
    assign o_cursor    = w_cursor;

endmodule

// File: tb/tb_jtframe_credits_console.sv
`timescale 1ns/1ps
module tb_jtframe_credits_console;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'd0;
    logic       din_valid = 1'b0;
    logic       clr = 1'b0;
    logic       din_ready, vram_we, busy;
    logic [7:0] vram_din;
    logic [9:0] vram_addr, cursor;

    jtframe_credits_console dut (
        .i_clk(clk), .i_rst(rst), .i_din(din), .i_din_valid(din_valid),
        .o_din_ready(din_ready), .i_clr(clr), .o_vram_din(vram_din),
        .o_vram_addr(vram_addr), .o_vram_we(vram_we), .o_busy(busy),
        .o_cursor(cursor)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed { logic [9:0] a; logic [7:0] d; } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [7:0] b;
        logic       wr;
        logic [9:0] a;
        logic [7:0] d;
        logic [9:0] cur;
    } vec_t;
    vec_t tv[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: every VRAM write must match the next expected entry
    always @(negedge clk) begin
        if (vram_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", vram_addr, vram_din);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(vram_addr), 32'(e.a));
                chk("wr_data", 32'(vram_din), 32'(e.d));
            end
        end
    end

    task automatic wait_ready(input int lim);
        int t;
        t = 0;
        while (din_ready !== 1'b1 && t < lim) begin
            @(negedge clk);
            t++;
        end
        if (t >= lim) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got ready=%0b expected 1 within %0d cycles", din_ready, lim);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        wait_ready(3000);
        din = b;
        din_valid = 1'b1;
        @(posedge clk);
        #1 din_valid = 1'b0;
    endtask

    task automatic push_clear(input logic colour);
        for (int i = 0; i < 1024; i++) exp_q.push_back({10'(i), colour, 7'h20});
    endtask

    task automatic wait_clear_done(input string name);
        int cnt;
        cnt = 0;
        @(negedge clk);
        while (busy === 1'b1 && cnt < 1100) begin
            cnt++;
            @(negedge clk);
        end
        chk({name, "_busy_cycles"}, 32'(cnt), 32'd1024);
        chk({name, "_cursor"}, 32'(cursor), 32'd0);
        chk({name, "_ready"}, 32'(din_ready), 32'd1);
        chk({name, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        tv[0]  = '{8'h41, 1'b1, 10'd0,  8'hC1, 10'd1};
        tv[1]  = '{8'h42, 1'b1, 10'd1,  8'hC2, 10'd2};
        tv[2]  = '{8'h01, 1'b0, 10'd0,  8'h00, 10'd2};
        tv[3]  = '{8'h78, 1'b1, 10'd2,  8'h78, 10'd3};
        tv[4]  = '{8'h0A, 1'b0, 10'd0,  8'h00, 10'd32};
        tv[5]  = '{8'h02, 1'b0, 10'd0,  8'h00, 10'd32};
        tv[6]  = '{8'h79, 1'b1, 10'd32, 8'hF9, 10'd33};
        tv[7]  = '{8'h0D, 1'b0, 10'd0,  8'h00, 10'd32};
        tv[8]  = '{8'h1F, 1'b0, 10'd0,  8'h00, 10'd32};
        tv[9]  = '{8'h7F, 1'b0, 10'd0,  8'h00, 10'd32};
        tv[10] = '{8'hC1, 1'b0, 10'd0,  8'h00, 10'd32};
        tv[11] = '{8'h7E, 1'b1, 10'd32, 8'hFE, 10'd33};
        tv[12] = '{8'h20, 1'b1, 10'd33, 8'hA0, 10'd34};
        tv[13] = '{8'h00, 1'b0, 10'd0,  8'h00, 10'd34};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_we",    32'(vram_we),   32'd0);
        chk("rst_addr",  32'(vram_addr), 32'd0);
        chk("rst_din",   32'(vram_din),  32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_cursor",32'(cursor),    32'd0);
        chk("rst_ready", 32'(din_ready), 32'd0);
        rst = 1'b0;
        #1 chk("ready_after_rst", 32'(din_ready), 32'd1);

        // table-driven bytes: printable, control and ignored codes
        foreach (tv[i]) begin
            if (tv[i].wr) exp_q.push_back({tv[i].a, tv[i].d});
            send_byte(tv[i].b);
            @(negedge clk);
            chk($sformatf("we_latency[%0d]", i), 32'(vram_we), 32'(tv[i].wr));
            chk($sformatf("ready_n1[%0d]", i), 32'(din_ready), 32'(!tv[i].wr));
            wait_ready(10);
            chk($sformatf("cursor[%0d]", i), 32'(cursor), 32'(tv[i].cur));
        end

        // form feed clears the page in colour 1
        push_clear(1'b1);
        send_byte(8'h0C);
        wait_clear_done("ff_clear");

        // 33 printable bytes: column wrap into row 1
        for (int i = 0; i < 33; i++) begin
            logic [7:0] b;
            b = 8'h61 + 8'(i % 26);
            exp_q.push_back({10'(i), 1'b1, b[6:0]});
            send_byte(b);
        end
        @(negedge clk);
        wait_ready(10);
        chk("col_wrap_cursor", 32'(cursor), 32'd33);
        chk("col_wrap_q_empty", 32'(exp_q.size()), 32'd0);

        // line feeds down to row 31, then one more wraps the page
        for (int i = 0; i < 30; i++) send_byte(8'h0A);
        @(negedge clk);
        chk("row31_cursor", 32'(cursor), 32'd992);
        send_byte(8'h0A);
        @(negedge clk);
        chk("row_wrap_cursor", 32'(cursor), 32'd0);

        // clr and din_valid together: clr wins, byte is dropped
        @(negedge clk);
        push_clear(1'b1);
        din = 8'h5A;
        din_valid = 1'b1;
        clr = 1'b1;
        #1 chk("ready_with_clr", 32'(din_ready), 32'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        din_valid = 1'b0;
        wait_clear_done("clr_vs_din");

        // clr during WRITE: pending write completes, then clear
        exp_q.push_back({10'd0, 8'hD1});
        send_byte(8'h51);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        push_clear(1'b1);
        wait_clear_done("clr_in_write");

        // reset in the middle of a clear
        for (int i = 0; i <= 500; i++) exp_q.push_back({10'(i), 8'hA0});
        send_byte(8'h0C);
        begin
            int t;
            t = 0;
            @(negedge clk);
            while (!(vram_we === 1'b1 && vram_addr == 10'd500) && t < 1100) begin
                @(negedge clk);
                t++;
            end
            chk("mid_clear_reached", 32'(vram_addr), 32'd500);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_we",     32'(vram_we),   32'd0);
        chk("abort_addr",   32'(vram_addr), 32'd0);
        chk("abort_din",    32'(vram_din),  32'd0);
        chk("abort_busy",   32'(busy),      32'd0);
        chk("abort_cursor", 32'(cursor),    32'd0);
        chk("abort_q_empty",32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 0x1B 0x3F: hex print when enabled, otherwise a plain '?'
`ifdef JTFRAME_CREDITS_CONSOLE_HEX_EN
        exp_q.push_back({10'd0, 8'hB3});
        exp_q.push_back({10'd1, 8'hC6});
        send_byte(8'h1B);
        send_byte(8'h3F);
        @(negedge clk);
        wait_ready(20);
        chk("hex_cursor", 32'(cursor), 32'd2);
`else
        exp_q.push_back({10'd0, 8'hBF});
        send_byte(8'h1B);
        send_byte(8'h3F);
        @(negedge clk);
        wait_ready(20);
        chk("hex_off_cursor", 32'(cursor), 32'd1);
`endif

        repeat (5) @(negedge clk);
        chk("final_q_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
